ram_port_arbiter: RTL and testbench

- Two-requester round-robin arbiter and command sequencer for the single-port SPI-slave RAM.
- Turns each requester's word-level read/write into the RAM's two-beat command protocol on ram_din/ram_rx_valid.
- Captures the RAM read response (ram_dout on ram_tx_valid) and returns it to the granted requester with a one-cycle ack.
- Sits between the RAM and any two on-chip masters, e.g. a debug port and the SPI slave's host path.

---
 rtl/ram_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter that turns word reads/writes into the
// RAM's two-beat command protocol and returns read data with a one-cycle ack.
module ram_port_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [ADDR_SIZE-1:0] a_wdata,
  output logic                 a_ack,
  output logic [ADDR_SIZE-1:0] a_rdata,
  output logic                 a_err,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [ADDR_SIZE-1:0] b_wdata,
  output logic                 b_ack,
  output logic [ADDR_SIZE-1:0] b_rdata,
  output logic                 b_err,
  output logic                 busy,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND_ADDR = 3'd1,
    S_SEND_DATA = 3'd2,
    S_WAIT_RD   = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_owner;       // 1 = requester B
  logic                   r_last_grant;  // 1 = requester B
  logic                   r_we;
  logic [ADDR_SIZE-1:0]   r_addr;
  logic [ADDR_SIZE-1:0]   r_wdata;
  logic [TW-1:0]          r_timer;
  logic [ADDR_SIZE+1:0]   r_din_last;
  logic [ADDR_SIZE-1:0]   r_a_rdata;
  logic [ADDR_SIZE-1:0]   r_b_rdata;
  logic                   r_a_err;
  logic                   r_b_err;

  logic                   w_any_req;
  logic                   w_grant_b;
  logic [TW-1:0]          w_timer_nxt;
  logic                   w_timeout;
  logic [ADDR_SIZE+1:0]   w_addr_beat;
  logic [ADDR_SIZE+1:0]   w_data_beat;

  // On a tie, B wins only if A was served last
  assign w_any_req   = a_req | b_req;
  assign w_grant_b   = b_req & (~a_req | ~r_last_grant);
  assign w_timer_nxt = r_timer + 1'b1;
  assign w_timeout   = (w_timer_nxt == TW'(TIMEOUT - 1));
  assign w_addr_beat = {(r_we ? 2'b00 : 2'b10), r_addr};
  assign w_data_beat = {(r_we ? 2'b01 : 2'b11), (r_we ? r_wdata : {ADDR_SIZE{1'b0}})};

  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;
  assign a_err   = r_a_err;
  assign b_err   = r_b_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_any_req) w_state_nxt = S_SEND_ADDR;
      S_SEND_ADDR: w_state_nxt = S_SEND_DATA;
      S_SEND_DATA: w_state_nxt = r_we ? S_DONE : S_WAIT_RD;
      S_WAIT_RD:   if (ram_tx_valid || w_timeout) w_state_nxt = S_DONE;
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ram_rx_valid = 1'b0;
    ram_din      = r_din_last;
    busy         = (r_state != S_IDLE);
    a_ack        = 1'b0;
    b_ack        = 1'b0;
    case (r_state)
      S_SEND_ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = w_addr_beat;
      end
      S_SEND_DATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = w_data_beat;
      end
      S_DONE: begin
        a_ack = ~r_owner;
        b_ack = r_owner;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_timer      <= '0;
      r_din_last   <= '0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
      r_a_err      <= 1'b0;
      r_b_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant_b;
            r_we    <= w_grant_b ? b_we    : a_we;
            r_addr  <= w_grant_b ? b_addr  : a_addr;
            r_wdata <= w_grant_b ? b_wdata : a_wdata;
          end
        end
        S_SEND_DATA: begin
          r_din_last <= w_data_beat;
          r_timer    <= '0;
          if (r_we) begin
            if (r_owner) r_b_err <= 1'b0;
            else         r_a_err <= 1'b0;
          end
        end
        S_WAIT_RD: begin
          r_timer <= w_timer_nxt;
          // Data arriving on the last allowed cycle still counts as success
          if (ram_tx_valid) begin
            if (r_owner) begin
              r_b_rdata <= ram_dout;
              r_b_err   <= 1'b0;
            end else begin
              r_a_rdata <= ram_dout;
              r_a_err   <= 1'b0;
            end
          end else if (w_timeout) begin
            if (r_owner) begin
              r_b_rdata <= '0;
              r_b_err   <= 1'b1;
            end else begin
              r_a_rdata <= '0;
              r_a_err   <= 1'b1;
            end
          end
        end
        S_DONE: r_last_grant <= r_owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM responder plus a transaction-level
// model of expected beats, ack latency, read data and error flags.
module tb_ram_port_arbiter;

  localparam int AW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic          a_ack, a_err, b_ack, b_err, busy, ram_rx_valid;
  logic [AW-1:0] a_rdata, b_rdata;
  logic [AW+1:0] ram_din;
  logic [AW-1:0] ram_dout = '0;
  logic          ram_tx_valid = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [AW-1:0] ref_mem [256];
  logic [AW-1:0] mdl_rdata [2];
  logic          mdl_err [2];

  logic [AW-1:0] ram_mem [256];
  logic [AW-1:0] m_waddr = '0, m_raddr = '0;
  int            m_cnt = 0;
  bit            m_armed = 0, m_init = 0;
  int            resp_delay = 0;
  bit            never_respond = 0, stray = 0;

  ram_port_arbiter #(.ADDR_SIZE(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .busy(busy), .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // RAM responder: decodes beats, answers a read-data beat after resp_delay cycles
  always @(negedge clk) begin
    if (!m_init) begin
      for (int i = 0; i < 256; i++) ram_mem[i] = AW'(i) ^ 8'h5A;
      m_init = 1;
    end
    ram_tx_valid = 1'b0;
    if (!rst_n) begin
      m_armed = 0;
    end else begin
      if (m_armed) begin
        if (m_cnt == 0) begin
          ram_tx_valid = 1'b1;
          ram_dout     = ram_mem[m_raddr];
          m_armed      = 0;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
      if (stray) begin
        ram_tx_valid = 1'b1;
        ram_dout     = 8'hEE;
      end
      if (ram_rx_valid) begin
        case (ram_din[AW+1:AW])
          2'b00: m_waddr = ram_din[AW-1:0];
          2'b01: ram_mem[m_waddr] = ram_din[AW-1:0];
          2'b10: m_raddr = ram_din[AW-1:0];
          default: if (!never_respond) begin
            m_armed = 1;
            m_cnt   = resp_delay;
          end
        endcase
      end
    end
  end

  task automatic model_reset();
    mdl_rdata[0] = '0; mdl_rdata[1] = '0;
    mdl_err[0]   = 1'b0; mdl_err[1] = 1'b0;
  endtask

  task automatic set_req(input bit who, input bit req, input bit we,
                         input logic [AW-1:0] addr, input logic [AW-1:0] wdata);
    if (who) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
    end
  endtask

  // One complete transaction from one requester, checked against the model
  task automatic do_txn(input bit who, input bit we, input logic [AW-1:0] addr,
                        input logic [AW-1:0] wdata, input int d, input bit nr,
                        input string tag);
    logic [AW+1:0] beat1, beat2;
    int            exp_k, ack_k;
    logic [AW-1:0] exp_rd;
    logic          exp_er;
    bit            got, other_seen, busy_ack, rx_ack;
    @(negedge clk);
    resp_delay    = d;
    never_respond = nr;
    beat1 = {(we ? 2'b00 : 2'b10), addr};
    beat2 = {(we ? 2'b01 : 2'b11), (we ? wdata : 8'h00)};
    exp_rd = mdl_rdata[who];
    exp_er = 1'b0;
    if (we) exp_k = 3;
    else if (!nr && d <= TO - 2) begin
      exp_k = 4 + d; exp_rd = ref_mem[addr];
    end else begin
      exp_k = 2 + TO; exp_rd = '0; exp_er = 1'b1;
    end
    set_req(who, 1'b1, we, addr, wdata);
    got = 0; other_seen = 0; ack_k = 0; busy_ack = 0; rx_ack = 1;
    for (int k = 1; k <= TO + 6 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_tests++;
        if (ram_rx_valid !== 1'b1 || ram_din !== beat1) begin
          n_fail++;
          $display("FAIL %s addr_beat: got rx=%b din=%h, want rx=1 din=%h", tag, ram_rx_valid, ram_din, beat1);
        end
      end
      if (k == 2) begin
        n_tests++;
        if (ram_rx_valid !== 1'b1 || ram_din !== beat2) begin
          n_fail++;
          $display("FAIL %s data_beat: got rx=%b din=%h, want rx=1 din=%h", tag, ram_rx_valid, ram_din, beat2);
        end
      end
      if ((who ? a_ack : b_ack) === 1'b1) other_seen = 1;
      if ((who ? b_ack : a_ack) === 1'b1) begin
        got = 1; ack_k = k; busy_ack = busy; rx_ack = ram_rx_valid;
      end
    end
    set_req(who, 1'b0, we, addr, wdata);
    n_tests++;
    if (!got || ack_k != exp_k) begin
      n_fail++;
      $display("FAIL %s ack_latency: got %0d (seen=%0d), want %0d", tag, ack_k, got, exp_k);
    end
    n_tests++;
    if (other_seen) begin
      n_fail++;
      $display("FAIL %s wrong_ack: non-owner ack seen, want none", tag);
    end
    n_tests++;
    if (busy_ack !== 1'b1 || rx_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_state: got busy=%b rx=%b, want busy=1 rx=0", tag, busy_ack, rx_ack);
    end
    mdl_rdata[who] = exp_rd;
    mdl_err[who]   = exp_er;
    if (we) ref_mem[addr] = wdata;
    n_tests++;
    if (a_rdata !== mdl_rdata[0] || a_err !== mdl_err[0] ||
        b_rdata !== mdl_rdata[1] || b_err !== mdl_err[1]) begin
      n_fail++;
      $display("FAIL %s resp: got a=%h/%b b=%h/%b, want a=%h/%b b=%h/%b", tag,
               a_rdata, a_err, b_rdata, b_err, mdl_rdata[0], mdl_err[0], mdl_rdata[1], mdl_err[1]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (a_ack !== 1'b0 || b_ack !== 1'b0 || busy !== 1'b0 || ram_rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ack=%b%b busy=%b rx=%b, want all 0", a_ack, b_ack, busy, ram_rx_valid);
    end
    n_tests++;
    if (ram_din !== '0 || a_rdata !== '0 || b_rdata !== '0 || a_err !== 1'b0 || b_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got din=%h rd=%h/%h err=%b%b, want all 0", ram_din, a_rdata, b_rdata, a_err, b_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    do_txn(1'b0, 1'b1, 8'h3C, 8'hA5, 0, 1'b0, "single_write");
  endtask

  task automatic test_single_read();
    do_txn(1'b1, 1'b0, 8'h3C, 8'h00, 0, 1'b0, "single_read");
  endtask

  task automatic test_timeout();
    bit bad;
    do_txn(1'b0, 1'b0, 8'h5C, 8'h00, 0, 1'b1, "timeout");
    do_txn(1'b1, 1'b0, 8'h5D, 8'h00, TO - 2, 1'b0, "data_at_limit");
    do_txn(1'b1, 1'b0, 8'h5E, 8'h00, TO - 1, 1'b0, "data_too_late");
    repeat (3) @(negedge clk);
    stray = 1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) stray = 0;
      if (busy !== 1'b0 || a_ack !== 1'b0 || b_ack !== 1'b0 ||
          a_rdata !== mdl_rdata[0] || a_err !== mdl_err[0]) bad = 1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL stray_tx: got busy=%b ack=%b%b a=%h/%b, want idle and a=%h/%b",
               busy, a_ack, b_ack, a_rdata, a_err, mdl_rdata[0], mdl_err[0]);
    end
  endtask

  task automatic test_write_then_read();
    do_txn(1'b0, 1'b1, 8'hFF, 8'h00, 0, 1'b0, "wr_ff");
    do_txn(1'b0, 1'b0, 8'hFF, 8'h00, int'($urandom_range(0, 3)), 1'b0, "rd_ff");
  endtask

  task automatic test_random();
    bit            who, we, nr;
    logic [AW-1:0] addr, wdata;
    int            d;
    for (int i = 0; i < 40; i++) begin
      who   = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = AW'($urandom);
      if (i % 8 == 0) addr = 8'hFF;
      if (i % 8 == 1) addr = 8'h00;
      wdata = AW'($urandom);
      d     = int'($urandom_range(0, TO));
      nr    = ($urandom_range(0, 9) == 0);
      do_txn(who, we, addr, wdata, d, nr, "random");
    end
  endtask

  task automatic test_contention();
    bit got, own, both;
    int c0, prev;
    bit exp_owner;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    resp_delay = 0;
    never_respond = 0;
    set_req(1'b0, 1'b1, 1'b0, 8'h21, 8'h00);
    set_req(1'b1, 1'b1, 1'b0, 8'h42, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc; prev = 0; exp_owner = 1'b0;
    for (int n = 0; n < 6; n++) begin
      got = 0; both = 0; own = 0;
      for (int k = 0; k < 12 && !got; k++) begin
        @(negedge clk);
        if (a_ack === 1'b1 && b_ack === 1'b1) both = 1;
        if (a_ack === 1'b1 || b_ack === 1'b1) begin
          got = 1; own = (b_ack === 1'b1);
        end
      end
      n_tests++;
      if (!got || both || own != exp_owner) begin
        n_fail++;
        $display("FAIL contention_owner[%0d]: got seen=%0d both=%0d owner=%0d, want owner=%0d", n, got, both, own, exp_owner);
      end
      n_tests++;
      if ((n == 0 && cyc - c0 != 4) || (n > 0 && cyc - prev != 5)) begin
        n_fail++;
        $display("FAIL contention_timing[%0d]: got gap=%0d, want %0d", n, (n == 0) ? cyc - c0 : cyc - prev, (n == 0) ? 4 : 5);
      end
      mdl_rdata[exp_owner] = ref_mem[exp_owner ? 8'h42 : 8'h21];
      n_tests++;
      if (a_rdata !== mdl_rdata[0] || b_rdata !== mdl_rdata[1] || a_err !== 1'b0 || b_err !== 1'b0) begin
        n_fail++;
        $display("FAIL contention_data[%0d]: got a=%h/%b b=%h/%b, want a=%h/0 b=%h/0", n,
                 a_rdata, a_err, b_rdata, b_err, mdl_rdata[0], mdl_rdata[1]);
      end
      prev = cyc;
      exp_owner = ~exp_owner;
    end
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reset_mid_read();
    bit bad;
    @(negedge clk);
    never_respond = 1;
    set_req(1'b0, 1'b1, 1'b0, 8'h77, 8'h00);
    repeat (5) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || ram_rx_valid !== 1'b0 || a_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_read_state: got busy=%b rx=%b ack=%b, want busy=1 rx=0 ack=0", busy, ram_rx_valid, a_ack);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (busy !== 1'b0 || ram_rx_valid !== 1'b0 || a_ack !== 1'b0 || b_ack !== 1'b0 ||
        ram_din !== '0 || a_rdata !== '0 || a_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b rx=%b ack=%b%b din=%h a=%h/%b, want all 0",
               busy, ram_rx_valid, a_ack, b_ack, ram_din, a_rdata, a_err);
    end
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    never_respond = 0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || a_ack !== 1'b0 || b_ack !== 1'b0) bad = 1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL lost_txn: activity after reset, got busy=%b ack=%b%b, want 0", busy, a_ack, b_ack);
    end
    do_txn(1'b0, 1'b1, 8'h10, 8'h55, 0, 1'b0, "post_reset_wr");
    do_txn(1'b0, 1'b0, 8'h10, 8'h00, 1, 1'b0, "post_reset_rd");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = AW'(i) ^ 8'h5A;
    model_reset();
    test_reset();
    test_single_write();
    test_single_read();
    test_timeout();
    test_write_then_read();
    test_random();
    test_contention();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
